mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported synchronous memory between the instruction-fetch (IF) port and the
//   data-memory (DM) port of the 16-bit MIPS datapath. Grants one access at a time, sequences it
//   through fixed memory latency, returns read data and a one-cycle ack to the owning port.
//   DM has priority; a starvation counter guarantees IF forward progress.
// PARAMETERS
//   BUS_WIDTH     16  data width of all data buses
//   ADDR_WIDTH    8   word-address width
//   MEM_LATENCY   1   cycles from mem_en sample edge to valid mem_rdata (legal >= 1)
//   STARVE_LIMIT  3   consecutive DM grants while IF waits before IF is forced (legal >= 1)
// PORTS
//   clk        in   1           clock, all state on rising edge
//   rst        in   1           reset, asynchronous, active-low
//   if_req     in   1           IF access request (read only), held until if_ack
//   if_addr    in   ADDR_WIDTH  IF word address, stable while if_req
//   if_ack     out  1           one-cycle pulse: if_rdata valid
//   if_rdata   out  BUS_WIDTH   IF read data, held until next if_ack
//   dm_req     in   1           DM access request, held until dm_ack
//   dm_we      in   1           1 = write, 0 = read; stable while dm_req
//   dm_addr    in   ADDR_WIDTH  DM word address
//   dm_wdata   in   BUS_WIDTH   DM write data
//   dm_ack     out  1           one-cycle pulse: access complete (dm_rdata valid on reads)
//   dm_rdata   out  BUS_WIDTH   DM read data, held until next DM read ack
//   mem_en     out  1           memory access strobe, one cycle per access
//   mem_we     out  1           memory write enable, qualified by mem_en
//   mem_addr   out  ADDR_WIDTH  memory address
//   mem_wdata  out  BUS_WIDTH   memory write data
//   mem_rdata  in   BUS_WIDTH   memory read data
//   busy       out  1           1 in any state other than IDLE
//   owner_dm   out  1           1 while current/last grant belongs to DM
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low.
//   All outputs registered. Reset (rst=0): state IDLE, every output 0, starvation count 0.
//   FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//   - IDLE: if any req, select winner, latch addr/we/wdata -> ISSUE. No req: stay.
//   - ISSUE (1 cycle): mem_en=1, mem_we = dm_we for DM (0 for IF), mem_addr/mem_wdata driven.
//     Latency counter loaded with MEM_LATENCY.
//   - WAIT: counter decrements. At 0, capture mem_rdata into the owner's rdata register
//     (reads only; DM writes leave dm_rdata unchanged) -> ACK.
//   - ACK (1 cycle): owner's ack=1 -> IDLE. Requests are not sampled in ACK.
//   Timing: req first seen in IDLE cycle R -> mem_en in R+1 -> ack in R+MEM_LATENCY+2.
//   Throughput: one access per MEM_LATENCY+3 cycles under back-to-back requests.
//   mem_en, if_ack, dm_ack: never high more than one cycle per access. if_ack and dm_ack are never
//   high together.
//   mem_addr/mem_we/mem_wdata hold their value outside ISSUE. mem_we=0 whenever mem_en=0.
//   Arbitration in IDLE:
//   - only one req -> that port.
//   - both req -> DM, unless starve_cnt == STARVE_LIMIT, in which case IF.
//   - starve_cnt: +1 on each DM grant while if_req=1 (saturates at STARVE_LIMIT).
//     Cleared on any IF grant, and in any IDLE cycle with if_req=0.
//   owner_dm updates at grant; holds through IDLE.
//   Requests dropped before ack (protocol violation): the in-flight access still completes and acks.
//   Async reset mid-access: abort immediately with no ack. The memory write may or may not have
//   occurred; the requester must reissue.
// TESTING
//   1 Reset: rst=0 mid-WAIT of a DM read -> all outputs 0 immediately, no dm_ack after rst=1.
//   2 IF only, MEM_LATENCY=1, mem[0x10]=0xBEEF: if_req@R, if_addr=0x10 -> mem_en@R+1,
//     if_ack=1 with if_rdata=0xBEEF@R+3, busy=0@R+4.
//   3 DM write then read: dm_we=1, addr 0x22, wdata 0x1234 -> mem_we=1 for one cycle, dm_ack.
//     Then a read of 0x22 returns dm_rdata=0x1234. if_rdata unchanged throughout.
//   4 Simultaneous if_req/dm_req held high, STARVE_LIMIT=3 -> grant order DM,DM,DM,IF,DM,DM,DM,IF.
//     Acks spaced MEM_LATENCY+3 cycles apart; never both acks high together.
//   5 MEM_LATENCY=4: single IF read -> ack exactly 6 cycles after request seen. if_req held through
//     the ack cycle does not cause a re-grant until the following IDLE.
//   6 if_req toggling low between DM grants -> starve_cnt clears; IF never forced while if_req=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between the IF (read-only) and DM ports.
// DM has priority; a bounded starvation count forces an IF grant after STARVE_LIMIT DM wins.
module mem_port_arbiter #(
   parameter int BUS_WIDTH    = 16,
   parameter int ADDR_WIDTH   = 8,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_ack_o,
   output logic [BUS_WIDTH-1:0]  if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [BUS_WIDTH-1:0]  dm_wdata_i,
   output logic                  dm_ack_o,
   output logic [BUS_WIDTH-1:0]  dm_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [BUS_WIDTH-1:0]  mem_wdata_o,
   input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
   output logic                  busy_o,
   output logic                  owner_dm_o
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      lat_q, lat_d;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic                  we_q, we_d;
   logic                  owner_dm_q, owner_dm_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [BUS_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic                  if_ack_q, if_ack_d;
   logic                  dm_ack_q, dm_ack_d;
   logic [BUS_WIDTH-1:0]  if_rdata_q, if_rdata_d;
   logic [BUS_WIDTH-1:0]  dm_rdata_q, dm_rdata_d;
   logic                  busy_q, busy_d;
   logic                  grant_dm;

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      we_d        = we_q;
      owner_dm_d  = owner_dm_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      grant_dm    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A waiting IF port is forced through once DM has won STARVE_LIMIT times in a row.
            grant_dm = dm_req_i && !(if_req_i && (starve_q == STV_MAX));
            if (!if_req_i || (if_req_i && !grant_dm && !dm_req_i) || (if_req_i && !grant_dm)) begin
               starve_d = '0;
            end else if (starve_q != STV_MAX) begin
               starve_d = starve_q + STV_W'(1);
            end
            if (if_req_i || dm_req_i) begin
               state_d    = ST_ISSUE;
               owner_dm_d = grant_dm;
               we_d       = grant_dm && dm_we_i;
               mem_en_d   = 1'b1;
               mem_we_d   = grant_dm && dm_we_i;
               mem_addr_d = grant_dm ? dm_addr_i : if_addr_i;
               if (grant_dm) begin
                  mem_wdata_d = dm_wdata_i;
               end
            end
         end
         ST_ISSUE: begin
            lat_d   = LAT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q == CNT_W'(1)) begin
               state_d = ST_ACK;
               if (owner_dm_q) begin
                  dm_ack_d = 1'b1;
                  if (!we_q) begin
                     dm_rdata_d = mem_rdata_i;
                  end
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata_i;
               end
            end else begin
               lat_d = lat_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         lat_q       <= '0;
         starve_q    <= '0;
         we_q        <= 1'b0;
         owner_dm_q  <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         we_q        <= we_d;
         owner_dm_q  <= owner_dm_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_ack_o    = if_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_ack_o    = dm_ack_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;
   assign owner_dm_o  = owner_dm_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts every grant,
// strobe, ack and read-data value; a second instance covers a longer memory latency.
module tb_mem_port_arbiter;
   localparam int BW  = 16;
   localparam int AW  = 8;
   localparam int LAT = 1;
   localparam int SL  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr;
   logic [BW-1:0] dm_wdata;
   logic          if_ack, dm_ack, mem_en, mem_we, busy, owner_dm;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;

   logic          if_req4, dm_req4, dm_we4;
   logic [AW-1:0] if_addr4, dm_addr4;
   logic [BW-1:0] dm_wdata4;
   logic          if_ack4, dm_ack4, mem_en4, mem_we4, busy4, owner_dm4;
   logic [AW-1:0] mem_addr4;
   logic [BW-1:0] if_rdata4, dm_rdata4, mem_wdata4, mem_rdata4;

   mem_port_arbiter #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_dm_o(owner_dm));

   mem_port_arbiter #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MEM_LATENCY(4), .STARVE_LIMIT(SL)) dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req4), .if_addr_i(if_addr4), .if_ack_o(if_ack4), .if_rdata_o(if_rdata4),
      .dm_req_i(dm_req4), .dm_we_i(dm_we4), .dm_addr_i(dm_addr4), .dm_wdata_i(dm_wdata4),
      .dm_ack_o(dm_ack4), .dm_rdata_o(dm_rdata4),
      .mem_en_o(mem_en4), .mem_we_o(mem_we4), .mem_addr_o(mem_addr4), .mem_wdata_o(mem_wdata4),
      .mem_rdata_i(mem_rdata4), .busy_o(busy4), .owner_dm_o(owner_dm4));

   // Memory environments: data appears MEM_LATENCY cycles after the strobe edge, garbage otherwise.
   logic [BW-1:0] mem  [256];
   logic [BW-1:0] mem4 [256];
   logic [BW-1:0] pipe1;
   logic [BW-1:0] pipe4 [4];

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
      pipe1 <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hDEAD;
   end
   assign mem_rdata = pipe1;

   always @(posedge clk) begin
      if (mem_en4 && mem_we4) mem4[mem_addr4] = mem_wdata4;
      pipe4[0] <= (mem_en4 && !mem_we4) ? mem4[mem_addr4] : 16'hDEAD;
      for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
   end
   assign mem_rdata4 = pipe4[3];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Transaction-level reference: one access in flight, fixed schedule from its grant cycle.
   logic [BW-1:0] ref_mem [256];
   int            gnt_cyc = -100;
   int            free_at = 0;
   int            starve  = 0;
   bit            g_dm, g_we, m_owner;
   logic [AW-1:0] g_addr;
   logic [BW-1:0] g_wdata, g_data, m_if_rd, m_dm_rd;
   int            mode = 0;
   logic [7:0]    order;
   int            n_ord = 0;

   task automatic step();
      bit e_en, e_ack, dropped;
      if (cyc >= free_at) begin
         if (!if_req) starve = 0;
         if (if_req || dm_req) begin
            g_dm = dm_req && !(if_req && starve == SL);
            if (!g_dm) starve = 0;
            else if (if_req && starve < SL) starve++;
            g_we    = g_dm && dm_we;
            g_addr  = g_dm ? dm_addr : if_addr;
            g_wdata = dm_wdata;
            if (g_we) ref_mem[g_addr] = g_wdata;
            else g_data = ref_mem[g_addr];
            gnt_cyc = cyc;
            free_at = cyc + LAT + 3;
            m_owner = g_dm;
         end
      end
      @(negedge clk);
      cyc++;
      e_en  = (cyc == gnt_cyc + 1);
      e_ack = (cyc == gnt_cyc + LAT + 2);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_en && g_we);
      if (e_en) begin
         chk("mem_addr", mem_addr, g_addr);
         if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
      end
      if (e_ack) begin
         if (!g_dm) m_if_rd = g_data;
         else if (!g_we) m_dm_rd = g_data;
      end
      chk("if_ack", if_ack, e_ack && !g_dm);
      chk("dm_ack", dm_ack, e_ack && g_dm);
      chk("if_rdata", if_rdata, m_if_rd);
      chk("dm_rdata", dm_rdata, m_dm_rd);
      chk("busy", busy, (cyc > gnt_cyc) && (cyc < free_at));
      chk("owner_dm", owner_dm, m_owner);
      if (mode == 2 && mem_en && n_ord < 8) begin
         order = {order[6:0], owner_dm};
         n_ord++;
      end
      dropped = 1'b0;
      if (e_ack) begin
         if (mode == 2) begin
            if (g_dm) dm_addr = 8'h20 + 8'($urandom_range(0, 7));
            else if_addr = 8'h20 + 8'($urandom_range(0, 7));
         end else begin
            if (g_dm) dm_req = 1'b0;
            else if_req = 1'b0;
            dropped = 1'b1;
         end
      end
      if (mode == 1 && !dropped) begin
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = ($urandom_range(0, 8) == 0) ? 8'h10 : 8'h20 + 8'($urandom_range(0, 7));
         end
         if (!dm_req && $urandom_range(0, 2) == 0) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = 8'h20 + 8'($urandom_range(0, 7));
            dm_wdata = 16'($urandom);
         end
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (if_req || dm_req); k++) step();
      chk("drain_done", {30'd0, if_req, dm_req}, 32'd0);
      repeat (3) step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
         mem4[i]    = 16'($urandom);
      end
      mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF; mem4[8'h10] = 16'hBEEF;
      rst_n = 1'b0;
      if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
      if_req4 = 0; dm_req4 = 0; dm_we4 = 0; if_addr4 = 0; dm_addr4 = 0; dm_wdata4 = 0;
      m_if_rd = 0; m_dm_rd = 0; m_owner = 0; g_dm = 0; g_we = 0;
      g_addr = 0; g_wdata = 0; g_data = 0; order = 0;
      repeat (3) @(negedge clk);
      chk("rst_if_ack", if_ack, 0);     chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_ack", dm_ack, 0);     chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);         chk("rst_owner", owner_dm, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // DM read aborted by reset while waiting on the memory
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30;
      @(negedge clk);
      chk("abort_mem_en", mem_en, 1);
      @(negedge clk);
      chk("abort_busy_wait", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);       chk("abort_owner", owner_dm, 0);
      chk("abort_mem_en0", mem_en, 0);  chk("abort_mem_addr", mem_addr, 0);
      chk("abort_dm_ack", dm_ack, 0);   chk("abort_dm_rdata", dm_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1; dm_req = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("post_abort_dm_ack", dm_ack, 0);
         chk("post_abort_busy", busy, 0);
      end
      chk("post_abort_dm_rdata", dm_rdata, 0);
      cyc = 0; free_at = 0; gnt_cyc = -100; starve = 0;

      // IF-only read of 0xBEEF
      mode = 0;
      if_req = 1'b1; if_addr = 8'h10;
      drain();
      chk("t2_if_rdata", if_rdata, 16'hBEEF);

      // DM write then read-back of the same word
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h22; dm_wdata = 16'h1234;
      drain();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h22;
      drain();
      chk("t3_dm_rdata", dm_rdata, 16'h1234);
      chk("t3_if_rdata", if_rdata, 16'hBEEF);

      mode = 1;
      repeat (1500) step();
      mode = 0;
      drain();

      // Both ports held high: starvation forces every fourth grant to IF
      mode = 2;
      if_req = 1'b1; if_addr = 8'h21; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h22;
      repeat (8 * (LAT + 3) + 2) step();
      chk("grant_order", order, 8'b1110_1110);
      mode = 0;
      drain();

      mode = 1;
      repeat (600) step();
      mode = 0;
      drain();

      // MEM_LATENCY=4 instance: ack 6 cycles after the request, re-grant only after IDLE
      if_req4 = 1'b1; if_addr4 = 8'h10;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         chk($sformatf("t5_ack_k%0d", k), if_ack4, (k == 6) || (k == 13));
         chk($sformatf("t5_en_k%0d", k), mem_en4, (k == 1) || (k == 8));
         chk($sformatf("t5_busy_k%0d", k), busy4, (k != 7) && (k != 14));
         chk("t5_dm_ack", dm_ack4, 0);
         chk("t5_owner", owner_dm4, 0);
         if (k == 6) chk("t5_if_rdata", if_rdata4, 16'hBEEF);
         if (k == 8) if_req4 = 1'b0;
      end
      chk("t5_dm_rdata", dm_rdata4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
